regfile_2r1w: RTL and testbench
===============================

// Module: regfile_2r1w
// PURPOSE
//  Parametrised register file: one write port with byte enables, two independent registered read ports.
//  Adds write-first bypass and a sequential clear engine with busy status.
//  Provides architectural/config storage for datapath blocks; successor to the fixed 16x32 single-port file.
// PARAMETERS
//  WIDTH  32  data width in bits; must be a multiple of 8
//  DEPTH  16  number of entries, 2..256; need not be a power of 2
//  AW     $clog2(DEPTH)  address width; derived, not overridden
// PORTS
//  clk        in   1        clock, all logic on posedge
//  reset_n    in   1        reset, synchronous, active-low
//  wr_en      in   1        write request
//  wr_addr    in   AW       write entry index
//  wr_data    in   WIDTH    write data
//  wr_be      in   WIDTH/8  byte enables; bit k controls wr_data[8k+7:8k]
//  wr_ready   out  1        write accepted this cycle when high
//  rd_en_a    in   1        port A read request
//  rd_addr_a  in   AW       port A entry index
//  rd_data_a  out  WIDTH    port A read data, registered
//  rd_valid_a out  1        port A data valid, one-cycle pulse
//  rd_en_b / rd_addr_b / rd_data_b / rd_valid_b: identical for port B
//  clr_start  in   1        start sequential clear of all entries
//  busy       out  1        clear in progress
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - all entries, rd_data_*, rd_valid_* and busy go to 0; wr_ready goes to 1; FSM goes to IDLE.
//   - Reset overrides all other inputs, including mid-clear.
//  Write:
//   - Performed at posedge when wr_en && wr_ready; only bytes with wr_be set change.
//   - wr_be=0 is a no-op. wr_addr>=DEPTH is silently dropped.
//  Read:
//   - rd_en_x sampled at posedge; rd_data_x/rd_valid_x update at that edge (1-cycle latency).
//   - rd_valid_x is high for exactly one cycle per request.
//   - Without rd_en_x, rd_data_x holds its last value and rd_valid_x is 0.
//   - rd_addr_x>=DEPTH returns 0 with rd_valid_x=1.
//   - Ports A and B are fully independent; both may read the same address.
//  Bypass (write-first):
//   - A read and an accepted write to the same address in one cycle return the merged new data.
//   - Merged data = old bytes where wr_be=0, wr_data bytes where wr_be=1.
//  Clear FSM, states IDLE/CLEAR:
//   - IDLE->CLEAR on clr_start; clear pointer starts at 0.
//   - CLEAR zeroes one entry per cycle, pointer 0..DEPTH-1; goes CLEAR->IDLE after entry DEPTH-1 is zeroed.
//   - Clear takes DEPTH cycles; busy=1 and wr_ready=0 throughout CLEAR.
//   - wr_en during CLEAR is dropped, not queued. clr_start during CLEAR is ignored.
//   - Reads during CLEAR are legal and return current contents; an entry reads 0 in the cycle it is cleared.
//  Pointer width: AW bits; DEPTH=2^AW wraps with no overflow flag.
// CONFIGURATION
//  REGFILE_PARITY_EN defined:
//   - Each entry stores one even-parity bit, computed on the merged word at write and zeroed on clear/reset.
//   - Adds inputs/outputs:
//       par_inject  in   1  when high on an accepted write, stores inverted parity
//       par_err_a/b out  1  high with rd_valid_x when stored parity mismatches data (bypassed reads use the new parity)
//  REGFILE_PARITY_EN undefined: no parity storage and none of the above ports.
// STRUCTURE
//  Package regfile_pkg: state enum {IDLE, CLEAR}; function for byte-enable merge; function for parity.
//  Sub-module regfile_rd_port: address decode, range check, bypass mux, output registers (and parity check).
//  regfile_rd_port is instantiated twice, for A and B.
//  Top level holds the storage array, write logic and clear FSM.
// TESTING
//  1. Reset -> all rd reads of 0..DEPTH-1 return 0; wr_ready=1; busy=0.
//  2. Write 0xDEADBEEF to addr 3 with wr_be=4'b1111, then wr_be=4'b0010 with data 0x0000AA00
//     -> read A addr 3 one cycle later returns 0xDEADAAEF, rd_valid_a pulses once.
//  3. Same cycle: write 0x12345678 to addr 5, rd_en_a/rd_en_b on addr 5
//     -> both ports return 0x12345678 next cycle.
//  4. Fill all entries, pulse clr_start -> busy high exactly 16 cycles; write issued at cycle 4 of clear is dropped;
//     all entries read 0 afterwards.
//  5. reset_n low during cycle 7 of clear -> next cycle busy=0, FSM IDLE, contents 0, wr_ready=1.
//  6. (REGFILE_PARITY_EN) write addr 9 with par_inject=1 -> read 9 asserts par_err_a;
//     rewrite without inject -> par_err_a=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2R1W register file.
// Optional parity storage is enabled with REGFILE_PARITY_EN.
package regfile_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    // Helpers work on a wide container; callers zero-extend and truncate.
    localparam int MAX_W = 1024;
    localparam int MAX_B = MAX_W / 8;

    function automatic logic [MAX_W-1:0] be_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] be
    );
        logic [MAX_W-1:0] m;
        m = old_w;
        for (int k = 0; k < MAX_B; k++) begin
            if (be[k]) begin
                m[8*k +: 8] = new_w[8*k +: 8];
            end
        end
        return m;
    endfunction

    function automatic logic even_par(input logic [MAX_W-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/regfile_if.sv
// Write/read/clear bundle of the 2R1W register file.
// Parity pins exist only with REGFILE_PARITY_EN.
interface regfile_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [NB-1:0]    wr_be;
    logic             wr_ready;
    logic             rd_en_a;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] rd_data_a;
    logic             rd_valid_a;
    logic             rd_en_b;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] rd_data_b;
    logic             rd_valid_b;
    logic             clr_start;
    logic             busy;
`ifdef REGFILE_PARITY_EN
    logic             par_inject;
    logic             par_err_a;
    logic             par_err_b;
`endif

    modport master (
`ifdef REGFILE_PARITY_EN
        output par_inject,
        input  par_err_a,
        input  par_err_b,
`endif
        output wr_en,
        output wr_addr,
        output wr_data,
        output wr_be,
        input  wr_ready,
        output rd_en_a,
        output rd_addr_a,
        input  rd_data_a,
        input  rd_valid_a,
        output rd_en_b,
        output rd_addr_b,
        input  rd_data_b,
        input  rd_valid_b,
        output clr_start,
        input  busy
    );

    modport slave (
`ifdef REGFILE_PARITY_EN
        input  par_inject,
        output par_err_a,
        output par_err_b,
`endif
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  wr_be,
        output wr_ready,
        input  rd_en_a,
        input  rd_addr_a,
        output rd_data_a,
        output rd_valid_a,
        input  rd_en_b,
        input  rd_addr_b,
        output rd_data_b,
        output rd_valid_b,
        input  clr_start,
        output busy
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port with write-first bypass and range check.
// Parity check is present with REGFILE_PARITY_EN.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem [DEPTH],
`ifdef REGFILE_PARITY_EN
    input  logic             par [DEPTH],
    input  logic             wr_par,
    output logic             par_err,
`endif
    input  logic             wr_we,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_word,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    logic             in_range;
    logic             hit;
    logic [WIDTH-1:0] word_nxt;

    assign in_range = int'(rd_addr) < DEPTH;
    assign hit      = wr_we && (wr_idx == rd_addr);

    always_comb begin
        word_nxt = '0;
        if (hit) begin
            word_nxt = wr_word;
        end else if (in_range) begin
            word_nxt = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= word_nxt;
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    logic perr_nxt;

    // A bypassed read is checked against the parity being written.
    always_comb begin
        perr_nxt = 1'b0;
        if (hit) begin
            perr_nxt = even_par(MAX_W'(wr_word)) != wr_par;
        end else if (in_range) begin
            perr_nxt = even_par(MAX_W'(mem[rd_addr])) != par[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rd_en && perr_nxt;
        end
    end
`endif

endmodule

// File: rtl/regfile_2r1w.sv
// Register file: storage, byte-enable write port and clear FSM.
// Define REGFILE_PARITY_EN for per-entry even parity.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input logic     clk,
    input logic     reset_n,
    regfile_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    state_t           state;
    state_t           state_nxt;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_nxt;

    logic             wr_in_range;
    logic [WIDTH-1:0] old_word;
    logic [WIDTH-1:0] merged;
    logic             wr_we;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_word;

    assign bus.busy     = (state == CLEAR);
    assign bus.wr_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        unique case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + AW'(1);
                if (ptr == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign wr_in_range = int'(bus.wr_addr) < DEPTH;
    assign old_word    = wr_in_range ? mem[bus.wr_addr] : '0;
    assign merged      = WIDTH'(be_merge(MAX_W'(old_word),
                                         MAX_W'(bus.wr_data),
                                         MAX_B'(bus.wr_be)));

    // Clearing looks like a full-word write of zero to the read ports.
    always_comb begin
        wr_we   = 1'b0;
        wr_idx  = ptr;
        wr_word = '0;
        if (state == CLEAR) begin
            wr_we = 1'b1;
        end else if (bus.wr_en && wr_in_range && |bus.wr_be) begin
            wr_we   = 1'b1;
            wr_idx  = bus.wr_addr;
            wr_word = merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_we) begin
            mem[wr_idx] <= wr_word;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par [DEPTH];
    logic wr_par;

    assign wr_par = (state == IDLE)
                  ? (even_par(MAX_W'(wr_word)) ^ bus.par_inject)
                  : 1'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                par[i] <= 1'b0;
            end
        end else if (wr_we) begin
            par[wr_idx] <= wr_par;
        end
    end
`endif

    regfile_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rd_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_en    (bus.rd_en_a),
        .rd_addr  (bus.rd_addr_a),
        .mem      (mem),
`ifdef REGFILE_PARITY_EN
        .par      (par),
        .wr_par   (wr_par),
        .par_err  (bus.par_err_a),
`endif
        .wr_we    (wr_we),
        .wr_idx   (wr_idx),
        .wr_word  (wr_word),
        .rd_data  (bus.rd_data_a),
        .rd_valid (bus.rd_valid_a)
    );

    regfile_rd_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rd_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_en    (bus.rd_en_b),
        .rd_addr  (bus.rd_addr_b),
        .mem      (mem),
`ifdef REGFILE_PARITY_EN
        .par      (par),
        .wr_par   (wr_par),
        .par_err  (bus.par_err_b),
`endif
        .wr_we    (wr_we),
        .wr_idx   (wr_idx),
        .wr_word  (wr_word),
        .rd_data  (bus.rd_data_b),
        .rd_valid (bus.rd_valid_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomised and directed checks of regfile_2r1w against an array model.
// Parity scenario runs only with REGFILE_PARITY_EN.
module tb_regfile_2r1w;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int NB    = WIDTH / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    regfile_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_par [DEPTH];
    bit               m_busy;
    int               m_ptr;
    logic [WIDTH-1:0] e_da, e_db;
    bit               e_va, e_vb, e_ea, e_eb;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_be     = '0;
        bus.rd_en_a   = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_en_b   = 1'b0;
        bus.rd_addr_b = '0;
        bus.clr_start = 1'b0;
`ifdef REGFILE_PARITY_EN
        bus.par_inject = 1'b0;
`endif
    endtask

    // Predict from the rules, advance one clock, compare at the negedge.
    task automatic cycle();
        logic [WIDTH-1:0] nm [DEPTH];
        bit               np [DEPTH];
        bit               inj;
        int               a;
        inj = 1'b0;
`ifdef REGFILE_PARITY_EN
        inj = bus.par_inject;
`endif
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i] = '0;
                m_par[i] = 1'b0;
            end
            m_busy = 0; m_ptr = 0;
            e_da = '0; e_db = '0;
            e_va = 0; e_vb = 0; e_ea = 0; e_eb = 0;
        end else begin
            nm = m_mem;
            np = m_par;
            a  = int'(bus.wr_addr);
            if (m_busy) begin
                nm[m_ptr] = '0;
                np[m_ptr] = 1'b0;
            end else if (bus.wr_en && a < DEPTH && bus.wr_be != 0) begin
                for (int k = 0; k < NB; k++)
                    if (bus.wr_be[k]) nm[a][8*k +: 8] = bus.wr_data[8*k +: 8];
                np[a] = (^nm[a]) ^ inj;
            end
            e_va = bus.rd_en_a;
            e_ea = 0;
            if (bus.rd_en_a) begin
                a = int'(bus.rd_addr_a);
                e_da = (a < DEPTH) ? nm[a] : '0;
                e_ea = (a < DEPTH) && ((^nm[a]) != np[a]);
            end
            e_vb = bus.rd_en_b;
            e_eb = 0;
            if (bus.rd_en_b) begin
                a = int'(bus.rd_addr_b);
                e_db = (a < DEPTH) ? nm[a] : '0;
                e_eb = (a < DEPTH) && ((^nm[a]) != np[a]);
            end
            if (m_busy) begin
                m_ptr++;
                if (m_ptr == DEPTH) m_busy = 0;
            end else if (bus.clr_start) begin
                m_busy = 1;
                m_ptr  = 0;
            end
            m_mem = nm;
            m_par = np;
        end
        @(posedge clk);
        @(negedge clk);
        check("rd_data_a", 64'(bus.rd_data_a), 64'(e_da));
        check("rd_valid_a", 64'(bus.rd_valid_a), 64'(e_va));
        check("rd_data_b", 64'(bus.rd_data_b), 64'(e_db));
        check("rd_valid_b", 64'(bus.rd_valid_b), 64'(e_vb));
        check("busy", 64'(bus.busy), 64'(m_busy));
        check("wr_ready", 64'(bus.wr_ready), 64'(!m_busy));
`ifdef REGFILE_PARITY_EN
        check("par_err_a", 64'(bus.par_err_a), 64'(e_ea));
        check("par_err_b", 64'(bus.par_err_b), 64'(e_eb));
`endif
    endtask

    task automatic write(input int adr, input logic [WIDTH-1:0] d,
                         input logic [NB-1:0] be);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(adr);
        bus.wr_data = d;
        bus.wr_be   = be;
        cycle();
        bus.wr_en   = 1'b0;
    endtask

    // Read every entry through both ports; optionally demand zero.
    task automatic read_all(input bit want_zero);
        for (int i = 0; i < DEPTH; i++) begin
            bus.rd_en_a   = 1'b1;
            bus.rd_addr_a = AW'(i);
            bus.rd_en_b   = 1'b1;
            bus.rd_addr_b = AW'(DEPTH - 1 - i);
            cycle();
            if (want_zero) begin
                check("zero_a", 64'(bus.rd_data_a), 64'd0);
                check("zero_b", 64'(bus.rd_data_b), 64'd0);
            end
        end
        bus.rd_en_a = 1'b0;
        bus.rd_en_b = 1'b0;
    endtask

    initial begin
        int cnt;
        idle_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        cycle();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
        reset_n = 1'b1;
        read_all(1);

        write(3, 32'hDEADBEEF, 4'b1111);
        write(3, 32'h0000AA00, 4'b0010);
        bus.rd_en_a = 1'b1; bus.rd_addr_a = AW'(3);
        cycle();
        check("t2_data", 64'(bus.rd_data_a), 64'hDEADAAEF);
        check("t2_valid", 64'(bus.rd_valid_a), 64'd1);
        bus.rd_en_a = 1'b0;
        cycle();
        check("t2_pulse", 64'(bus.rd_valid_a), 64'd0);
        check("t2_hold", 64'(bus.rd_data_a), 64'hDEADAAEF);

        bus.rd_en_a = 1'b1; bus.rd_addr_a = AW'(5);
        bus.rd_en_b = 1'b1; bus.rd_addr_b = AW'(5);
        write(5, 32'h12345678, 4'b1111);
        check("t3_a", 64'(bus.rd_data_a), 64'h12345678);
        check("t3_b", 64'(bus.rd_data_b), 64'h12345678);
        bus.rd_en_a = 1'b0; bus.rd_en_b = 1'b0;

        write(7, 32'hCAFEF00D, 4'b0000);
        for (int i = 0; i < DEPTH; i++) write(i, $urandom, 4'b1111);
        bus.clr_start = 1'b1;
        cycle();
        bus.clr_start = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 40) begin
            if (cnt == 3) begin
                bus.wr_en = 1'b1; bus.wr_addr = '0;
                bus.wr_data = 32'hFFFFFFFF; bus.wr_be = 4'b1111;
            end
            bus.clr_start = (cnt == 8);
            bus.rd_en_a = 1'b1; bus.rd_addr_a = AW'(cnt % DEPTH);
            cycle();
            idle_inputs();
            cnt++;
        end
        check("t4_busy_cycles", 64'(cnt), 64'(DEPTH));
        read_all(1);

        for (int i = 0; i < DEPTH; i++) write(i, $urandom | 1, 4'b1111);
        bus.clr_start = 1'b1;
        cycle();
        bus.clr_start = 1'b0;
        for (int i = 1; i < 7; i++) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("t5_busy", 64'(bus.busy), 64'd0);
        check("t5_wr_ready", 64'(bus.wr_ready), 64'd1);
        read_all(1);

`ifdef REGFILE_PARITY_EN
        bus.par_inject = 1'b1;
        write(9, 32'h0F0F1234, 4'b1111);
        bus.par_inject = 1'b0;
        bus.rd_en_a = 1'b1; bus.rd_addr_a = AW'(9);
        cycle();
        check("t6_err_on", 64'(bus.par_err_a), 64'd1);
        write(9, 32'h0F0F1234, 4'b1111);
        check("t6_err_off", 64'(bus.par_err_a), 64'd0);
        bus.rd_en_a = 1'b0;
`endif

        for (int n = 0; n < 2000; n++) begin
            bus.wr_en     = $urandom_range(0, 1) == 1;
            bus.wr_addr   = AW'($urandom);
            bus.wr_data   = $urandom;
            bus.wr_be     = NB'($urandom);
            bus.rd_en_a   = $urandom_range(0, 9) < 6;
            bus.rd_addr_a = $urandom_range(0, 3) == 0 ? bus.wr_addr : AW'($urandom);
            bus.rd_en_b   = $urandom_range(0, 9) < 6;
            bus.rd_addr_b = $urandom_range(0, 3) == 0 ? bus.wr_addr : AW'($urandom);
            bus.clr_start = $urandom_range(0, 59) == 0;
`ifdef REGFILE_PARITY_EN
            bus.par_inject = $urandom_range(0, 7) == 0;
`endif
            reset_n = $urandom_range(0, 299) != 0;
            cycle();
        end
        reset_n = 1'b1;
        idle_inputs();
        read_all(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
